// File: rtl/dm_bus_bridge_if.sv
// Signal bundle between the CPU memory stage, the dm_bus_bridge and the data bus.
// The slave modport is the bridge's view; master is the view of the core and bus model that surround it.
interface dm_bus_bridge_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_dmtype;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        timeout;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_dmtype, bus_rdata, bus_ack,
    output busy, resp_valid, resp_rdata, misalign, bus_req, bus_we, bus_addr,
           bus_be, bus_wdata, timeout
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_dmtype, bus_rdata, bus_ack,
    input  busy, resp_valid, resp_rdata, misalign, bus_req, bus_we, bus_addr,
           bus_be, bus_wdata, timeout
  );
endinterface

// File: rtl/dm_bus_bridge.sv
// Memory-stage data access unit: turns core loads/stores into word-aligned bus transfers with byte
// enables and returns extended load data. Optional bus watchdog enabled by defining DM_TIMEOUT_EN.
module dm_bus_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic            clk,
  input  logic            rst,
  dm_bus_bridge_if.slave  io,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_too_small
    $error("CNT_W is too narrow to count to TIMEOUT_CYCLES");
  end

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  dmtype_q, dmtype_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        misalign_q, misalign_d;
  logic        aligned;
  logic [3:0]  req_be;
  logic [31:0] req_lanes;

  // Shift the addressed lanes down to bit 0, then extend according to the access type.
  function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [1:0] off,
                                              input logic [2:0] dmtype);
    logic [31:0] shifted;
    shifted = raw >> {off, 3'b000};
    case (dmtype)
      DM_HALF:  load_extend = {{16{shifted[15]}}, shifted[15:0]};
      DM_HALFU: load_extend = {16'h0000, shifted[15:0]};
      DM_BYTE:  load_extend = {{24{shifted[7]}}, shifted[7:0]};
      DM_BYTEU: load_extend = {24'h000000, shifted[7:0]};
      default:  load_extend = shifted;
    endcase
  endfunction

  always_comb begin
    aligned   = 1'b0;
    req_be    = 4'b0000;
    req_lanes = io.req_wdata;
    case (io.req_dmtype)
      DM_WORD: begin
        aligned = (io.req_addr[1:0] == 2'b00);
        req_be  = 4'b1111;
      end
      DM_HALF, DM_HALFU: begin
        aligned   = ~io.req_addr[0];
        req_be    = 4'b0011 << io.req_addr[1:0];
        req_lanes = {2{io.req_wdata[15:0]}};
      end
      DM_BYTE, DM_BYTEU: begin
        aligned   = 1'b1;
        req_be    = 4'b0001 << io.req_addr[1:0];
        req_lanes = {4{io.req_wdata[7:0]}};
      end
      default: aligned = 1'b0;
    endcase
  end

`ifdef DM_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dmtype_d     = dmtype_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    rdata_d      = 32'h0000_0000;
    misalign_d   = 1'b0;
`ifdef DM_TIMEOUT_EN
    cnt_d        = cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (io.req_valid) begin
          if (aligned) begin
            we_d     = io.req_we;
            addr_d   = {io.req_addr[31:2], 2'b00};
            dmtype_d = io.req_dmtype;
            be_d     = req_be;
            wdata_d  = req_lanes;
            state_d  = ST_BUS;
`ifdef DM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            misalign_d   = 1'b1;
            resp_valid_d = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (io.bus_ack) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = we_q ? 32'h0000_0000 : load_extend(io.bus_rdata, io.req_addr[1:0], dmtype_q);
`ifdef DM_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = 32'hDEAD_BEEF;
          timeout_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      addr_q       <= 32'h0000_0000;
      dmtype_q     <= 3'b000;
      be_q         <= 4'b0000;
      wdata_q      <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0000_0000;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dmtype_q     <= dmtype_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef DM_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign io.timeout = timeout_q;
`else
  assign io.timeout = 1'b0;
`endif

  // Handshake: bus_req rises on entry to BUS and holds, with address/enables/data stable, until the
  // cycle bus_ack is seen; resp_valid is a single-cycle pulse the pipeline consumes as busy falls.
  assign io.busy       = ((state_q == ST_IDLE) && io.req_valid) || (state_q == ST_BUS);
  assign io.bus_req    = (state_q == ST_BUS);
  assign io.bus_we     = we_q;
  assign io.bus_addr   = addr_q;
  assign io.bus_be     = be_q;
  assign io.bus_wdata  = wdata_q;
  assign io.resp_valid = resp_valid_q;
  assign io.resp_rdata = rdata_q;
  assign io.misalign   = misalign_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_dm_bus_bridge.sv
// Self-checking bench for dm_bus_bridge: directed cases, reset abort, random accesses and
// (with DM_TIMEOUT_EN) bus watchdog expiry.
module tb_dm_bus_bridge;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  // Expected response word: {timeout, misalign, resp_rdata}
  logic [33:0] exp_q[$];

  dm_bus_bridge_if dif ();

  dm_bus_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (dif.slave),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_size(input logic [2:0] t);
    case (t)
      3'b000:          model_size = 4;
      3'b001, 3'b010:  model_size = 2;
      3'b011, 3'b100:  model_size = 1;
      default:         model_size = 0;
    endcase
  endfunction

  function automatic logic model_ok(input logic [31:0] a, input logic [2:0] t);
    int sz;
    sz = model_size(t);
    model_ok = (sz != 0) && ((int'(a[1:0]) % sz) == 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] t);
    model_be = 4'b0000;
    for (int k = 0; k < model_size(t); k++) model_be[int'(a[1:0]) + k] = 1'b1;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] a, input logic [2:0] t,
                                              input logic [31:0] wd);
    model_wdata = 32'h0;
    for (int k = 0; k < model_size(t); k++) model_wdata[(int'(a[1:0]) + k) * 8 +: 8] = wd[k * 8 +: 8];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] t,
                                             input logic [31:0] rd);
    logic [31:0] v;
    int          off;
    int          sz;
    logic        sgn;
    off = int'(a[1:0]);
    sz  = model_size(t);
    v   = 32'h0;
    for (int k = 0; k < sz; k++) v[k * 8 +: 8] = rd[(off + k) * 8 +: 8];
    sgn = (t == 3'b001 || t == 3'b011) ? v[sz * 8 - 1] : 1'b0;
    for (int b = sz * 8; b < 32; b++) v[b] = sgn;
    model_load = v;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && dif.resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 34'(dif.resp_valid), 34'd0);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("resp", {dif.timeout, dif.misalign, dif.resp_rdata}, e);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] t);
    dif.req_valid  = 1'b1;
    dif.req_we     = we;
    dif.req_addr   = a;
    dif.req_wdata  = wd;
    dif.req_dmtype = t;
  endtask

  // ack_dly: number of BUS cycles without ack before the ack cycle.
  task automatic run_access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [2:0] t, input int ack_dly, input logic [31:0] rd);
    logic [31:0] mask;
    @(negedge clk);
    check("idle_before_req", 34'(dbg_state), 34'(S_IDLE));
    drive_req(we, a, wd, t);
    if (!model_ok(a, t)) exp_q.push_back({1'b0, 1'b1, 32'h0});
    else exp_q.push_back({1'b0, 1'b0, (we ? 32'h0 : model_load(a, t, rd))});
    #1;
    check("busy_on_req", 34'(dif.busy), 34'd1);
    @(negedge clk);
    dif.req_valid = 1'b0;
    if (!model_ok(a, t)) begin
      check("mis_pulse", 34'(dif.misalign), 34'd1);
      check("mis_no_bus", 34'(dif.bus_req), 34'd0);
      check("mis_idle", 34'(dbg_state), 34'(S_IDLE));
      return;
    end
    mask = 32'h0;
    for (int k = 0; k < 4; k++) if (model_be(a, t)[k]) mask[k * 8 +: 8] = 8'hFF;
    check("bus_addr", 34'(dif.bus_addr), 34'({a[31:2], 2'b00}));
    check("bus_be", 34'(dif.bus_be), 34'(model_be(a, t)));
    check("bus_we", 34'(dif.bus_we), 34'(we));
    if (we) check("bus_wdata", 34'(dif.bus_wdata & mask), 34'(model_wdata(a, t, wd)));
    for (int i = 0; i < ack_dly; i++) begin
      check("bus_req_wait", 34'(dif.bus_req), 34'd1);
      check("busy_wait", 34'(dif.busy), 34'd1);
      @(negedge clk);
      check("bus_addr_stable", 34'(dif.bus_addr), 34'({a[31:2], 2'b00}));
    end
    check("bus_req_ack", 34'(dif.bus_req), 34'd1);
    dif.bus_ack   = 1'b1;
    dif.bus_rdata = rd;
    @(negedge clk);
    dif.bus_ack   = 1'b0;
    dif.bus_rdata = $urandom();
    check("resp_valid", 34'(dif.resp_valid), 34'd1);
    check("resp_busy", 34'(dif.busy), 34'd0);
    check("resp_bus_req", 34'(dif.bus_req), 34'd0);
    check("resp_state", 34'(dbg_state), 34'(S_RESP));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    dif.req_valid  = 1'b0;
    dif.req_we     = 1'b0;
    dif.req_addr   = 32'h0;
    dif.req_wdata  = 32'h0;
    dif.req_dmtype = 3'b000;
    dif.bus_rdata  = 32'h0;
    dif.bus_ack    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state", 34'(dbg_state), 34'(S_IDLE));
    check("rst_outs", {dif.busy, dif.resp_valid, dif.misalign, dif.bus_req, dif.bus_we, dif.timeout},
          34'd0);
    check("rst_bus", 34'({dif.bus_be, dif.bus_addr[29:0]}), 34'd0);
    check("rst_wdata", 34'(dif.bus_wdata), 34'd0);
    check("rst_rdata", 34'(dif.resp_rdata), 34'd0);
    rst = 1'b0;

    // Directed cases from the plan
    run_access(1'b0, 32'h0000_1003, 32'h0, 3'b011, 2, 32'h80FF_FF7F);
    run_access(1'b1, 32'h0000_2002, 32'h0000_ABCD, 3'b001, 0, 32'h5555_5555);
    run_access(1'b0, 32'h0000_0000, 32'h0, 3'b010, 0, 32'h1234_8001);
    run_access(1'b0, 32'h0000_0000, 32'h0, 3'b001, 1, 32'h1234_8001);
    run_access(1'b0, 32'h0000_0006, 32'h0, 3'b000, 0, 32'h0);
    run_access(1'b0, 32'h0000_0011, 32'h0, 3'b001, 0, 32'h0);
    run_access(1'b0, 32'h0000_0010, 32'h0, 3'b101, 0, 32'h0);
    run_access(1'b1, 32'h0000_3001, 32'h0000_00A5, 3'b100, 0, 32'h0);
    run_access(1'b0, 32'h0000_4002, 32'h0, 3'b100, 0, 32'h00F0_0000);
    run_access(1'b1, 32'h0000_5004, 32'hCAFE_F00D, 3'b000, 3, 32'h0);

    // Reset while waiting on the bus: access is abandoned silently
    @(negedge clk);
    drive_req(1'b0, 32'h0000_6000, 32'h0, 3'b000);
    @(negedge clk);
    dif.req_valid = 1'b0;
    check("pre_rst_bus_req", 34'(dif.bus_req), 34'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_bus_req", 34'(dif.bus_req), 34'd0);
    check("abort_outs", {dif.busy, dif.resp_valid, dif.misalign, dif.bus_we, dif.bus_be, dif.bus_addr[27:0]},
          34'd0);
    check("abort_state", 34'(dbg_state), 34'(S_IDLE));
    repeat (2) @(negedge clk);
    check("abort_no_resp", 34'(dif.resp_valid), 34'd0);
    run_access(1'b0, 32'h0000_6000, 32'h0, 3'b000, 1, 32'h89AB_CDEF);

    // Long wait on the bus (no watchdog expiry at 3 idle cycles with limit 4)
    run_access(1'b0, 32'h0000_7001, 32'h0, 3'b011, 3, 32'h0000_7F00);
`ifndef DM_TIMEOUT_EN
    run_access(1'b0, 32'h0000_7002, 32'h0, 3'b010, 12, 32'hBEEF_0000);
`endif

    // Random accesses, issued back-to-back after each response
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra;
      ra = {16'h0, 16'($urandom_range(0, 16'hFFFF))};
      run_access(1'($urandom_range(0, 1)), ra, $urandom(), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 3), $urandom());
    end

`ifdef DM_TIMEOUT_EN
    // Watchdog expiry: four BUS cycles without ack
    @(negedge clk);
    drive_req(1'b0, 32'h0000_0040, 32'h0, 3'b000);
    exp_q.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    dif.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_bus_req", 34'(dif.bus_req), 34'd1);
      @(negedge clk);
    end
    check("to_resp_valid", 34'(dif.resp_valid), 34'd1);
    check("to_pulse", 34'(dif.timeout), 34'd1);
    check("to_bus_req_drop", 34'(dif.bus_req), 34'd0);
    @(negedge clk);
    check("to_idle", 34'(dbg_state), 34'(S_IDLE));
    check("to_pulse_end", 34'(dif.timeout), 34'd0);
    // Ack on the expiry cycle wins
    run_access(1'b0, 32'h0000_0044, 32'h0, 3'b000, 3, 32'h0123_4567);
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 34'(exp_q.size()), 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    check("global_timeout", 34'd1, 34'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
